// File: rtl/real_clk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : real_clk_pkg
// Description : Shared definitions for the real-clock display path:
//               active-low seven-segment patterns {g,f,e,d,c,b,a} for the
//               digits 0..9, the capture FSM state encoding and the time
//               field limits.
// Revision    : 1.0 - initial release
// ============================================================================
package real_clk_pkg;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;

    // Capture FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HELD   = 2'd2
    } cap_state_e;

    // Field limits (exclusive upper bounds)
    localparam logic [6:0] SEC_LIMIT  = 7'd60;
    localparam logic [6:0] MIN_LIMIT  = 7'd60;
    localparam logic [6:0] HOUR_LIMIT = 7'd24;

endpackage
`default_nettype wire

// File: rtl/ssd_to_bcd.sv
`default_nettype none
// ============================================================================
// Module      : ssd_to_bcd
// Description : Combinational decoder from an active-low seven-segment
//               pattern back to a BCD digit.
//   seg   in  7 : active-low segments {g,f,e,d,c,b,a}
//   digit out 4 : decoded digit 0..9 (0 when the pattern is not recognised)
//   valid out 1 : pattern is one of the ten accepted digit patterns
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_to_bcd
    import real_clk_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       valid
);

    always_comb begin
        digit = 4'd0;
        valid = 1'b1;
        case (seg)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: valid = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ssd_capture.sv
`default_nettype none
// ============================================================================
// Module      : ssd_capture
// Description : Display-side receiver for the real clock. Watches the
//               multiplexed seven-segment bus, captures each digit once its
//               anode has been stable, assembles a four-digit frame and
//               converts it to binary time fields.
//   clk          in  1 : system clock
//   reset        in  1 : synchronous active-high reset
//   mode         in  1 : 0 = digits show MM:SS, 1 = digits show HH:MM
//   basys_anode  in  4 : active-low digit enables, bit 3 = leftmost digit
//   display_ssd  in  7 : active-low segments {g,f,e,d,c,b,a}
//   q_seconds    out 6 : last committed seconds
//   q_minutes    out 6 : last committed minutes
//   q_hours      out 5 : last committed hours
//   frame_valid  out 1 : one-cycle pulse on a frame commit
//   seg_error    out 1 : one-cycle pulse on a rejected digit or frame
// Parameter   : STABLE_CYCLES (1..255) identical anode samples per capture
// Build macro : SSD_CAPTURE_RANGE_CHECK_EN - reject out-of-range frames
//               instead of truncating them to the port width
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_capture
    import real_clk_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode,
    input  logic [3:0] basys_anode,
    input  logic [6:0] display_ssd,
    output logic [5:0] q_seconds,
    output logic [5:0] q_minutes,
    output logic [4:0] q_hours,
    output logic       frame_valid,
    output logic       seg_error
);

    localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

    cap_state_e       state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [3:0]       anode_prev_q, anode_prev_d;
    logic [3:0]       mask_q, mask_d;
    logic [3:0][3:0]  slot_q, slot_d;
    logic             mode_q, mode_d;
    logic [5:0]       q_seconds_q, q_seconds_d;
    logic [5:0]       q_minutes_q, q_minutes_d;
    logic [4:0]       q_hours_q, q_hours_d;
    logic             frame_valid_q, frame_valid_d;
    logic             seg_error_q, seg_error_d;

    logic             onehot;
    logic [1:0]       idx;
    logic             same;
    logic             capture;
    logic [7:0]       cnt_next;
    logic [3:0]       mask_next;
    logic [6:0]       upper;
    logic [6:0]       lower;
    logic [3:0]       dec_digit;
    logic             dec_valid;

    ssd_to_bcd u_dec (
        .seg   (display_ssd),
        .digit (dec_digit),
        .valid (dec_valid)
    );

    // Anode qualification: only one-hot-low values select a slot; blank and
    // illegal values are treated alike by the FSM.
    always_comb begin
        onehot = 1'b1;
        idx    = 2'd0;
        case (basys_anode)
            4'b0111: idx = 2'd3;
            4'b1011: idx = 2'd2;
            4'b1101: idx = 2'd1;
            4'b1110: idx = 2'd0;
            default: onehot = 1'b0;
        endcase
    end

    // Stability tracking. Coming from IDLE the previous sample is not
    // trusted, so the first one-hot sample always restarts the count at 1.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        anode_prev_d = basys_anode;
        capture      = 1'b0;
        same         = (state_q != ST_IDLE) && (basys_anode == anode_prev_q);
        cnt_next     = same ? (cnt_q + 8'd1) : 8'd1;

        if (!onehot) begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
        end else if (state_q == ST_HELD && same) begin
            state_d = ST_HELD;
        end else begin
            cnt_d = cnt_next;
            if (cnt_next >= STABLE_C) begin
                capture = 1'b1;
                state_d = ST_HELD;
            end else begin
                state_d = ST_SETTLE;
            end
        end
    end

    // Slot capture, frame assembly and commit
    always_comb begin
        slot_d        = slot_q;
        mask_next     = mask_q;
        mask_d        = mask_q;
        mode_d        = mode_q;
        q_seconds_d   = q_seconds_q;
        q_minutes_d   = q_minutes_q;
        q_hours_d     = q_hours_q;
        frame_valid_d = 1'b0;
        seg_error_d   = 1'b0;

        if (capture) begin
            if (dec_valid) begin
                slot_d[idx]    = dec_digit;
                mask_next[idx] = 1'b1;
            end else begin
                seg_error_d = 1'b1;
                mask_next   = 4'b0000;
            end
        end

        // Fields are built from slot_d so the digit captured this cycle is
        // already part of the frame.
        upper = 7'(slot_d[3]) * 7'd10 + 7'(slot_d[2]);
        lower = 7'(slot_d[1]) * 7'd10 + 7'(slot_d[0]);

        if (mode != mode_q) begin
            // Mode change beats a completing capture: the frame is dropped.
            mode_d = mode;
            mask_d = 4'b0000;
        end else if (mask_next == 4'b1111) begin
            mask_d = 4'b0000;
`ifdef SSD_CAPTURE_RANGE_CHECK_EN
            if (!mode_q) begin
                if (upper < MIN_LIMIT && lower < SEC_LIMIT) begin
                    q_minutes_d   = upper[5:0];
                    q_seconds_d   = lower[5:0];
                    frame_valid_d = 1'b1;
                end else begin
                    seg_error_d   = 1'b1;
                end
            end else begin
                if (upper < HOUR_LIMIT && lower < MIN_LIMIT) begin
                    q_hours_d     = upper[4:0];
                    q_minutes_d   = lower[5:0];
                    frame_valid_d = 1'b1;
                end else begin
                    seg_error_d   = 1'b1;
                end
            end
`else
            if (!mode_q) begin
                q_minutes_d = upper[5:0];
                q_seconds_d = lower[5:0];
            end else begin
                q_hours_d   = upper[4:0];
                q_minutes_d = lower[5:0];
            end
            frame_valid_d = 1'b1;
`endif
        end else begin
            mask_d = mask_next;
        end
    end

`ifndef SSD_CAPTURE_RANGE_CHECK_EN
    // Bit 6 of each field only matters when out-of-range frames are checked.
    logic unused_field_msb;
    assign unused_field_msb = upper[6] ^ lower[6];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 8'd0;
            anode_prev_q  <= 4'b1111;
            mask_q        <= 4'b0000;
            slot_q        <= '0;
            mode_q        <= 1'b0;
            q_seconds_q   <= 6'd0;
            q_minutes_q   <= 6'd0;
            q_hours_q     <= 5'd0;
            frame_valid_q <= 1'b0;
            seg_error_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            anode_prev_q  <= anode_prev_d;
            mask_q        <= mask_d;
            slot_q        <= slot_d;
            mode_q        <= mode_d;
            q_seconds_q   <= q_seconds_d;
            q_minutes_q   <= q_minutes_d;
            q_hours_q     <= q_hours_d;
            frame_valid_q <= frame_valid_d;
            seg_error_q   <= seg_error_d;
        end
    end

    assign q_seconds   = q_seconds_q;
    assign q_minutes   = q_minutes_q;
    assign q_hours     = q_hours_q;
    assign frame_valid = frame_valid_q;
    assign seg_error   = seg_error_q;

endmodule
`default_nettype wire

// File: doc/ssd_capture.md
# ssd_capture

Display-side receiver for the real clock. It watches the multiplexed seven-segment bus (`basys_anode`, `display_ssd`) that the display stage drives. It decodes each strobed digit back to BCD, assembles a full four-digit frame, and converts that frame to binary time fields. It serves as an in-system checker and loopback source: its `q_*` outputs must match the counter values that produced the display.

## Interface
Parameters:
- `STABLE_CYCLES`, default 4: consecutive identical one-hot anode samples required before a digit is captured (range 1..255).

Ports:
- `clk` in 1: system clock. The only clock in the block.
- `reset` in 1: synchronous, active-high reset.
- `mode` in 1: display mode, same meaning as at the display stage.
  - 0: digits show MM:SS.
  - 1: digits show HH:MM.
- `basys_anode` in 4: active-low digit enables. Bit 3 is the leftmost digit.
- `display_ssd` in 7: active-low segments {g,f,e,d,c,b,a}.
- `q_seconds` out 6: last committed seconds, binary.
- `q_minutes` out 6: last committed minutes, binary.
- `q_hours` out 5: last committed hours, binary.
- `frame_valid` out 1: one-cycle pulse when a frame commits.
- `seg_error` out 1: one-cycle pulse on a rejected digit or frame.

## Operation
- Inputs are in the `clk` domain. They are sampled every cycle with no synchronizer.
- Anode qualification:
  - A one-hot-low anode gives slot index 3..0.
  - All-high is blank.
  - Any other value is illegal.
- FSM states:
  - IDLE: anode is blank or illegal. Stability counter is held at 0.
  - SETTLE: a one-hot anode is present. The counter increments while the anode equals the previous sample.
    - Anode changes to a different one-hot value: counter restarts at 1 for the new slot.
    - Anode goes blank or illegal: go to IDLE.
    - Counter reaches `STABLE_CYCLES`: capture and go to HELD.
  - HELD: digit already captured. Stay until the anode changes.
    - Changes to a one-hot value: go to SETTLE with counter 1.
    - Changes to blank or illegal: go to IDLE.
- Capture:
  - `display_ssd` is decoded to BCD 0..9. Accepted patterns (hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Valid pattern: store the digit in slot register [idx] and set mask[idx]. A re-capture of a slot already in the mask overwrites it.
  - Invalid pattern: pulse `seg_error` and clear the mask.
- Commit: when the mask reaches 4'b1111, clear the mask and form the two fields:
  - upper = slot3*10 + slot2
  - lower = slot1*10 + slot0
- Field mapping:
  - mode=0: upper goes to `q_minutes`, lower goes to `q_seconds`.
  - mode=1: upper goes to `q_hours`, lower goes to `q_minutes`.
  - The field not covered by the current mode holds its value.
  - A successful commit pulses `frame_valid`.
- Mode change: when `mode` differs from its registered copy, the mask is cleared and the registered copy updated. No error is raised. Mode is only examined at commit via the registered copy.
- Blank periods between digits do not clear the mask.
- Arithmetic: the tens*10+units product is formed 7 bits wide (max 99), then range-checked or truncated per Configuration.

## Timing
- Reset values: `q_seconds`=0, `q_minutes`=0, `q_hours`=0, `frame_valid`=0, `seg_error`=0. Internally, mask=0, FSM=IDLE, counter=0, registered mode=0.
- Capture occurs in the cycle where the anode has been identical for `STABLE_CYCLES` consecutive samples (first sample counts as 1).
- `seg_error` for a bad segment pattern is asserted the cycle after capture.
- Commit latency: `q_*` and `frame_valid` update the cycle after the capture that completes the mask.
- Simultaneous capture completion and mode change: the mode change wins. The mask is cleared, no commit occurs, and there is no pulse.
- Reset asserted mid-frame discards the partial frame at the next edge.

## Configuration
- `SSD_CAPTURE_RANGE_CHECK_EN` defined:
  - At commit, the frame is rejected if seconds or minutes ≥ 60 or hours ≥ 24.
  - On rejection, `seg_error` pulses instead of `frame_valid` and outputs hold.
- `SSD_CAPTURE_RANGE_CHECK_EN` undefined:
  - No range check.
  - Values are truncated to the port width: low 6 bits for seconds and minutes, low 5 bits for hours.
  - Commit always pulses `frame_valid`.

## Structure
- Shared package `real_clk_pkg` holds:
  - the ten segment-pattern constants
  - the FSM state enum (IDLE, SETTLE, HELD)
  - field limits 60 and 24
- Sub-module `ssd_to_bcd` is the combinational decoder. Input: 7-bit pattern. Outputs: 4-bit digit and `valid`.

## Test plan
- Reset, mode=0, `STABLE_CYCLES`=4, displayed time 12:34:56. Drive anode 0111/1011/1101/1110 with ssd 30/19/12/02, each held 8 cycles. Required: `frame_valid` pulse 1 cycle after the 4th capture, `q_minutes`=34, `q_seconds`=56, `q_hours`=0.
- mode=1 with digits 2,3,5,9. Required: `q_hours`=23, `q_minutes`=59, `q_seconds` unchanged.
- Anode held only 3 cycles per digit. Required: no capture and no `frame_valid`. Anode held exactly 4 cycles: capture.
- Slot1 ssd=7F (blank pattern). Required: `seg_error` pulse, no commit. The next clean four-digit frame commits normally.
- Toggle `mode` after 2 captures. Required: no pulses. A commit occurs only after 4 further captures.
- With the macro defined, mode=0 digits 7,5,0,0. Required: `seg_error` pulse and outputs hold. Without the macro: `q_minutes`=75&63=11, and `frame_valid` pulses.
